i_type: RTL and testbench
=========================

// Module: i_type
// PURPOSE
//  Execute unit for RV32I register-immediate ALU ops (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI).
//  Sits in the single-cycle datapath beside the R/B/L/S units; rv1 and imm arrive from regfile/imm-gen.
//  Produces regdata_I for the writeback mux.
//  Connects through interface Instr_IO, modport I_type_io_ports.
// PARAMETERS
//  XLEN  32  datapath width; only 32 is supported
// PORTS (all carried by Instr_IO.I_type_io_ports)
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  idata       in   32  current instruction word; only [14:12] (funct3) and [30] are used
//  iaddr       in   32  PC of idata; unused by this block
//  imm         in   32  signed, sign-extended I-immediate
//  rv1         in   32  signed, rs1 value
//  rv2         in   32  signed, rs2 value; unused by this block
//  regdata_I   out  32  combinational result for the writeback mux
//  regdata_Iq  out  32  regdata_I registered on rising clk for pipelined/debug use
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - regdata_I is purely combinational from idata[14:12], idata[30], rv1 and imm.
//    Zero-cycle latency; it must settle within the same cycle the inputs change. No handshake.
//  - Opcode is not decoded here. The writeback mux selects regdata_I only for OP-IMM.
//  - Decode on funct3 = idata[14:12]:
//      000 ADDI   rv1 + imm, mod 2^32 (overflow wraps, no flag)
//      010 SLTI   {31'b0, signed(rv1) < signed(imm)}
//      011 SLTIU  {31'b0, unsigned(rv1) < unsigned(imm)}
//      100 XORI   rv1 ^ imm
//      110 ORI    rv1 | imm
//      111 ANDI   rv1 & imm
//      001 SLLI   rv1 << imm[4:0]
//      101        idata[30]=0: SRLI, logical rv1 >> imm[4:0]
//                 idata[30]=1: SRAI, arithmetic rv1 >>> imm[4:0]
//  - Shift amount is always imm[4:0]. imm[31:5] is ignored for shifts; 0 gives rv1 unchanged.
//  - idata[30] is ignored for every funct3 except 101.
//  - No other idata bits may influence the result; they can be X in test.
//  - Unknown or X funct3 (default branch) drives regdata_I = 0.
//  - regdata_Iq: reset=1 at posedge clk gives 0; otherwise it captures regdata_I. Reset value 0.
//  - regdata_I has no reset dependence. It stays a valid function of its inputs during reset.
// STRUCTURE
//  - riscv_pkg holds:
//      enum i_func (3-bit): ADDI=000, SLLI=001, SLTI=010, SLTIU=011, XORI=100, SRLI=101, ORI=110, ANDI=111
//      FUNCT3_MSB=14, FUNCT3_LSB=12, ALT_BIT=30
//  - Cast idata[14:12] to i_func and use a unique case on it; the default branch drives 0.
//  - Optional sub-module i_shifter (rv1, shamt[4:0], arith) implementing SLL/SRL/SRA.
//    It is shareable with the R-type unit.
//  - Instr_IO interface is defined in its own shared file, not in this module.
// TESTING (check regdata_I 1 ns after applying inputs; other idata bits left X)
//  1. ADDI rv1=617, imm=511 -> 1128. ADDI rv1=32'h7FFFFFFF, imm=1 -> 32'h80000000.
//  2. SLTI 989,295 -> 0; SLTI -5,3 -> 1; SLTIU 980,533 -> 0; SLTIU -5,3 -> 0.
//  3. XORI 679,91 -> 764; ORI 234,592 -> 762; ANDI 503,746 -> 226.
//  4. SLLI rv1=843, imm=750 (shamt 14) -> 13811712. SLLI with shamt 0 -> rv1.
//  5. funct3=101: idata[30]=0, rv1=949, imm=3 -> 118; idata[30]=1, rv1=-949, imm=3 -> -119.
//     idata[30]=0, rv1=-949, imm=3 -> 32'h1FFFFF89.
//  6. regdata_Iq: hold reset=1 for one clk -> 0. Release, ADDI 617+511 -> 1128 after the next posedge.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I decode types and field positions
package riscv_pkg;

    // funct3 encodings of the OP-IMM instruction group
    typedef enum logic [2:0] {
        ADDI  = 3'b000,
        SLLI  = 3'b001,
        SLTI  = 3'b010,
        SLTIU = 3'b011,
        XORI  = 3'b100,
        SRLI  = 3'b101,
        ORI   = 3'b110,
        ANDI  = 3'b111
    } i_func;

    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT3_LSB = 12;
    localparam int ALT_BIT    = 30;

endpackage

// File: rtl/i_shifter.sv
// rtl/i_shifter.sv - barrel shifter for SLL/SRL/SRA, shareable with the R-type unit
module i_shifter (
    input  logic [31:0] i_rv1,
    input  logic [4:0]  i_shamt,
    input  logic        i_arith,
    output logic [31:0] o_sll,
    output logic [31:0] o_sr
);

    // Left shift is always available; right shift picks fill by i_arith
    always_comb begin
        o_sll = i_rv1 << i_shamt;
        if (i_arith) begin
            o_sr = $unsigned($signed(i_rv1) >>> i_shamt);
        end else begin
            o_sr = i_rv1 >> i_shamt;
        end
    end

endmodule

// File: rtl/i_type.sv
// rtl/i_type.sv - RV32I register-immediate ALU execute unit
module i_type
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] idata,
    input  logic [31:0] iaddr,
    input  logic [31:0] imm,
    input  logic [31:0] rv1,
    input  logic [31:0] rv2,
    output logic [31:0] regdata_I,
    output logic [31:0] regdata_Iq
);

    i_func       w_funct3;
    logic        w_alt;
    logic [31:0] w_sll;
    logic [31:0] w_sr;
    logic [31:0] w_result;
    logic [31:0] r_regdata_q;
    logic        w_unused;

    // Only funct3 and bit 30 of the instruction matter; the rest, the PC
    // and rs2 are folded here so they are visibly consumed
    assign w_unused = ^{idata[31], idata[29:15], idata[11:0], iaddr, rv2};

    assign w_funct3 = i_func'(idata[FUNCT3_MSB:FUNCT3_LSB]);
    assign w_alt    = idata[ALT_BIT];

    // Shift amount is the low five immediate bits; bit 30 selects SRA over SRL
    i_shifter u_shifter (
        .i_rv1   (rv1),
        .i_shamt (imm[4:0]),
        .i_arith (w_alt),
        .o_sll   (w_sll),
        .o_sr    (w_sr)
    );

    // Result select on funct3; unknown encodings fall to zero
    always_comb begin
        w_result = '0;
        unique case (w_funct3)
            ADDI:    w_result = rv1 + imm;
            SLTI:    w_result = {31'b0, $signed(rv1) < $signed(imm)};
            SLTIU:   w_result = {31'b0, rv1 < imm};
            XORI:    w_result = rv1 ^ imm;
            ORI:     w_result = rv1 | imm;
            ANDI:    w_result = rv1 & imm;
            SLLI:    w_result = w_sll;
            SRLI:    w_result = w_sr;
            default: w_result = '0;
        endcase
    end

    assign regdata_I = w_result;

    // Registered copy of the result for pipelined/debug consumers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regdata_q <= '0;
        end else begin
            r_regdata_q <= w_result;
        end
    end

    assign regdata_Iq = r_regdata_q;

endmodule

// File: tb/tb_i_type.sv
// tb/tb_i_type.sv - self-checking bench for the I-type execute unit
module tb_i_type;

    logic        clk;
    logic        reset;
    logic [31:0] idata;
    logic [31:0] iaddr;
    logic [31:0] imm;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [31:0] regdata_I;
    logic [31:0] regdata_Iq;

    int n_cmp;
    int n_fail;

    i_type dut (
        .clk        (clk),
        .reset      (reset),
        .idata      (idata),
        .iaddr      (iaddr),
        .imm        (imm),
        .rv1        (rv1),
        .rv2        (rv2),
        .regdata_I  (regdata_I),
        .regdata_Iq (regdata_Iq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour from the instruction definitions, using wide integers
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p2, q;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sh = int'(b[4:0]);
        p2 = longint'(1) << sh;
        case (f3)
            3'd0: begin
                q = (ua + ub) % 64'sd4294967296;
                return q[31:0];
            end
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (ua < ub) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd6: return a | b;
            3'd7: return a & b;
            3'd1: begin
                q = (ua * p2) % 64'sd4294967296;
                return q[31:0];
            end
            default: begin
                if (alt) begin
                    if (sa < 0) q = (sa - (p2 - 1)) / p2;
                    else        q = sa / p2;
                end else begin
                    q = ua / p2;
                end
                return q[31:0];
            end
        endcase
    endfunction

    task automatic apply(input logic [2:0] f3, input logic alt,
                         input logic [31:0] a, input logic [31:0] b);
        idata      = 'x;
        idata[14:12] = f3;
        idata[30]    = alt;
        rv1 = a;
        imm = b;
        iaddr = $urandom;
        rv2   = $urandom;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dir(input string tag, input logic [2:0] f3, input logic alt,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        apply(f3, alt, a, b);
        #1;
        check(tag, regdata_I, exp);
        check({tag, "_model"}, regdata_I, ref_model(f3, alt, a, b));
    endtask

    initial begin
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] a, b, exp;

        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        apply(3'd0, 1'b0, 32'd617, 32'd511);

        // Reset: registered output clears, combinational path stays live
        @(posedge clk);
        #1;
        check("reset_q", regdata_Iq, 32'd0);
        check("comb_in_reset", regdata_I, 32'd1128);
        @(posedge clk);
        #1;
        check("reset_q_hold", regdata_Iq, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("q_after_release", regdata_Iq, 32'd1128);

        dir("addi",       3'd0, 1'b0, 32'd617,        32'd511, 32'd1128);
        dir("addi_wrap",  3'd0, 1'b0, 32'h7FFFFFFF,   32'd1,   32'h80000000);
        dir("addi_alt",   3'd0, 1'b1, 32'hFFFFFFFF,   32'd2,   32'd1);
        dir("slti_0",     3'd2, 1'b0, 32'd989,        32'd295, 32'd0);
        dir("slti_1",     3'd2, 1'b0, 32'hFFFFFFFB,   32'd3,   32'd1);
        dir("sltiu_0",    3'd3, 1'b0, 32'd980,        32'd533, 32'd0);
        dir("sltiu_neg",  3'd3, 1'b0, 32'hFFFFFFFB,   32'd3,   32'd0);
        dir("xori",       3'd4, 1'b0, 32'd679,        32'd91,  32'd764);
        dir("ori",        3'd6, 1'b1, 32'd234,        32'd592, 32'd762);
        dir("andi",       3'd7, 1'b0, 32'd503,        32'd746, 32'd226);
        dir("slli",       3'd1, 1'b0, 32'd843,        32'd750, 32'd13811712);
        dir("slli_0",     3'd1, 1'b1, 32'hDEADBEEF,   32'hFFFFFFE0, 32'hDEADBEEF);
        dir("srli",       3'd5, 1'b0, 32'd949,        32'd3,   32'd118);
        dir("srai_neg",   3'd5, 1'b1, 32'hFFFFFC4B,   32'd3,   32'hFFFFFF89);
        dir("srli_neg",   3'd5, 1'b0, 32'hFFFFFC4B,   32'd3,   32'h1FFFFF89);
        dir("srai_31",    3'd5, 1'b1, 32'h80000000,   32'd31,  32'hFFFFFFFF);

        // Randomized operations, both combinational and registered paths
        for (int i = 0; i < 300; i++) begin
            f3  = 3'($urandom_range(0, 7));
            alt = 1'($urandom);
            a   = $urandom;
            b   = $urandom;
            if (i % 4 == 0) b = {{20{b[11]}}, b[11:0]};
            exp = ref_model(f3, alt, a, b);
            @(negedge clk);
            apply(f3, alt, a, b);
            #1;
            check($sformatf("rand_comb_%0d_f%0d", i, f3), regdata_I, exp);
            @(posedge clk);
            #1;
            check($sformatf("rand_q_%0d", i), regdata_Iq, exp);
        end

        // Reset in mid-stream clears the register again
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_q", regdata_Iq, 32'd0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
